// File: rtl/wb_trace_monitor.sv
// Write-back retirement monitor: counts retirements/redirects and buffers {pc, instr, redirect} in a FWFT FIFO.
// Latency: one edge to counters/FIFO; head outputs combinational. Full FIFO drops (OVERWRITE=0) or evicts oldest (OVERWRITE=1).
// Optional JAL/JALR link-value check enabled by defining TRACE_LINK_CHECK_EN.
module wb_trace_monitor #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 8,
    parameter int CNTW      = 32,
    parameter int OVERWRITE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [XLEN-1:0]          wb_pc,
    input  logic [31:0]              wb_instr,
    input  logic                     wb_regwrite,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_wdata,
    input  logic                     freeze,
    input  logic                     clear,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [31:0]              rd_instr,
    output logic                     rd_redirect,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CNTW-1:0]          retired,
    output logic [CNTW-1:0]          redirects,
    output logic                     frozen,
    output logic                     link_err,
    output logic [XLEN-1:0]          link_err_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, TRACK, FROZEN} state_t;

    state_t              state_q, state_d;
    logic [XLEN-1:0]     last_pc_q;
    logic [CNTW-1:0]     retired_q, redirects_q;
    logic                overflow_q;
    logic [AW:0]         wr_ptr_q, rd_ptr_q;
    logic [XLEN-1:0]     mem_pc    [DEPTH];
    logic [31:0]         mem_instr [DEPTH];
    logic                mem_redir [DEPTH];

    logic                capture, redirect, link_bad;
    logic [CW-1:0]       occ;
    logic                empty, full, pop, do_write, evict;

    assign capture  = wb_valid && (state_q != FROZEN);
    assign redirect = (state_q == TRACK) && (wb_pc != last_pc_q + XLEN'(4));

`ifdef TRACE_LINK_CHECK_EN
    logic                link_err_q;
    logic [XLEN-1:0]     link_err_pc_q;
    logic                is_link;

    assign is_link  = ((wb_instr[6:0] == 7'b1101111) || (wb_instr[6:0] == 7'b1100111))
                      && wb_regwrite && (wb_rd != 5'd0);
    assign link_bad = capture && is_link && (wb_wdata != wb_pc + XLEN'(4));

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            link_err_q    <= 1'b0;
            link_err_pc_q <= '0;
        end else if (link_bad && !link_err_q) begin
            link_err_q    <= 1'b1;
            link_err_pc_q <= wb_pc;
        end
    end

    assign link_err    = link_err_q;
    assign link_err_pc = link_err_pc_q;
`else
    logic unused_link;
    assign unused_link = ^{wb_regwrite, wb_rd, wb_wdata};
    assign link_bad    = 1'b0;
    assign link_err    = 1'b0;
    assign link_err_pc = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = FROZEN;
        endcase
        if ((freeze || link_bad) && state_q != FROZEN) state_d = FROZEN;
        if (clear) state_d = IDLE;
    end

    assign occ   = wr_ptr_q - rd_ptr_q;
    assign empty = (occ == '0);
    assign full  = (occ == CW'(DEPTH));
    assign pop   = rd_en && !empty && !clear;
    // A pop in the same cycle always frees a slot for the incoming entry.
    assign do_write = capture && !clear && (!full || pop || (OVERWRITE != 0));
    assign evict    = capture && !clear && full && !pop && (OVERWRITE != 0);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state_q     <= IDLE;
            last_pc_q   <= '0;
            retired_q   <= '0;
            redirects_q <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                last_pc_q <= wb_pc;
                retired_q <= retired_q + CNTW'(1);
                if (redirect) redirects_q <= redirects_q + CNTW'(1);
                if (full && !pop) overflow_q <= 1'b1;
            end
            if (do_write)     wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop || evict) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && rst) begin
            mem_pc[wr_ptr_q[AW-1:0]]    <= wb_pc;
            mem_instr[wr_ptr_q[AW-1:0]] <= wb_instr;
            mem_redir[wr_ptr_q[AW-1:0]] <= redirect;
        end
    end

    assign rd_valid    = !empty;
    assign rd_pc       = empty ? '0    : mem_pc[rd_ptr_q[AW-1:0]];
    assign rd_instr    = empty ? 32'd0 : mem_instr[rd_ptr_q[AW-1:0]];
    assign rd_redirect = empty ? 1'b0  : mem_redir[rd_ptr_q[AW-1:0]];
    assign count       = occ;
    assign overflow    = overflow_q;
    assign retired     = retired_q;
    assign redirects   = redirects_q;
    assign frozen      = (state_q == FROZEN);

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Directed bench: two monitors (drop / evict on full) share one stimulus stream.
module tb_wb_trace_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [31:0] wb_instr = '0;
    logic        wb_regwrite = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_wdata = '0;
    logic        freeze = 1'b0;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;

    logic        v0, v1, rr0, rr1, ov0, ov1, fz0, fz1, le0, le1;
    logic [31:0] pc0, pc1, in0, in1, ret0, ret1, red0, red1, lp0, lp1;
    logic [3:0]  cnt0, cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_trace_monitor #(.XLEN(32), .DEPTH(8), .CNTW(32), .OVERWRITE(0)) u_drop (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .freeze(freeze), .clear(clear), .rd_en(rd_en),
        .rd_valid(v0), .rd_pc(pc0), .rd_instr(in0), .rd_redirect(rr0), .count(cnt0),
        .overflow(ov0), .retired(ret0), .redirects(red0), .frozen(fz0),
        .link_err(le0), .link_err_pc(lp0));

    wb_trace_monitor #(.XLEN(32), .DEPTH(8), .CNTW(32), .OVERWRITE(1)) u_evict (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .freeze(freeze), .clear(clear), .rd_en(rd_en),
        .rd_valid(v1), .rd_pc(pc1), .rd_instr(in1), .rd_redirect(rr1), .count(cnt1),
        .overflow(ov1), .retired(ret1), .redirects(red1), .frozen(fz1),
        .link_err(le1), .link_err_pc(lp1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
        wb_valid = 1'b1; wb_pc = pc; wb_instr = instr;
        tick();
        wb_valid = 1'b0; wb_regwrite = 1'b0; wb_rd = '0; wb_wdata = '0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // reset
        tick(); tick();
        rst = 1'b1;
        check("rst_valid", v0, 0);
        check("rst_count", cnt0, 0);
        check("rst_retired", ret0, 0);
        check("rst_redirects", red0, 0);
        check("rst_overflow", ov0, 0);
        check("rst_frozen", fz0, 0);
        check("rst_pc", pc0, 0);
        check("rst_link_err", le0, 0);

        // short program with one taken JAL
        retire(32'h00, 32'h00100093);
        retire(32'h04, 32'h00200113);
        check("prog_head_pc", pc0, 32'h00);
        check("prog_head_instr", in0, 32'h00100093);
        retire(32'h08, 32'h002081B3);
        wb_regwrite = 1'b1; wb_rd = 5'd4; wb_wdata = 32'h10;
        retire(32'h0C, 32'h00C0026F);
        retire(32'h18, 32'h002082B3);
        retire(32'h1C, 32'h00100313);
        check("prog_retired", ret0, 6);
        check("prog_redirects", red0, 1);
        check("prog_count", cnt0, 6);
        check("prog_link_ok", le0, 0);
        check("prog_rdir0", rr0, 0); pop();
        check("prog_rdir1", rr0, 0); pop();
        check("prog_pc2", pc0, 32'h08);
        check("prog_rdir2", rr0, 0); pop();
        check("prog_rdir3", rr0, 0); pop();
        check("prog_pc4", pc0, 32'h18);
        check("prog_rdir4", rr0, 1); pop();
        check("prog_rdir5", rr0, 0); pop();
        check("prog_empty_valid", v0, 0);
        check("prog_empty_pc", pc0, 0);
        pop();
        check("pop_empty_count", cnt0, 0);
        check("prog_retired_kept", ret0, 6);

        // ten sequential retirements into an 8-deep FIFO
        do_clear();
        check("clr_retired", ret0, 0);
        for (int i = 0; i < 10; i++) retire(32'(i * 4), 32'h00000013);
        check("ovf0_count", cnt0, 8);
        check("ovf0_flag", ov0, 1);
        check("ovf0_head", pc0, 32'h00);
        check("ovf0_retired", ret0, 10);
        check("ovf0_redirects", red0, 0);
        check("ovf1_count", cnt1, 8);
        check("ovf1_flag", ov1, 1);
        check("ovf1_head", pc1, 32'h08);
        for (int i = 0; i < 7; i++) pop();
        check("ovf0_last", pc0, 32'h1C);
        check("ovf1_last", pc1, 32'h24);
        pop();
        check("ovf1_drained", v1, 0);
        check("ovf1_drained_pc", pc1, 0);
        check("ovf0_drained", v0, 0);

        // full FIFO with simultaneous push and pop
        do_clear();
        check("clr_overflow", ov0, 0);
        for (int i = 0; i < 8; i++) retire(32'(i * 4), 32'h00000013);
        check("full_count", cnt0, 8);
        check("full_no_ovf", ov0, 0);
        rd_en = 1'b1;
        retire(32'h20, 32'h00000013);
        rd_en = 1'b0;
        check("pp_count", cnt0, 8);
        check("pp_no_ovf", ov0, 0);
        check("pp_head", pc0, 32'h04);
        check("pp1_no_ovf", ov1, 0);
        for (int i = 0; i < 7; i++) pop();
        check("pp_tail", pc0, 32'h20);
        check("pp1_tail", pc1, 32'h20);

        // clear beats a concurrent retirement
        do_clear();
        retire(32'h100, 32'h00000013);
        retire(32'h104, 32'h00000013);
        retire(32'h108, 32'h00000013);
        check("pre_clr_count", cnt0, 3);
        clear = 1'b1;
        retire(32'h10C, 32'h00000013);
        clear = 1'b0;
        check("clrv_retired", ret0, 0);
        check("clrv_count", cnt0, 0);
        retire(32'h500, 32'h00000013);
        check("clrv_first_rdir", rr0, 0);
        check("clrv_first_cnt", red0, 0);
        retire(32'h600, 32'h00000013);
        check("clrv_jump_redirects", red0, 1);

        // freeze: same-cycle retirement recorded, later ones ignored
        freeze = 1'b1;
        retire(32'h604, 32'h00000013);
        freeze = 1'b0;
        check("frz_flag", fz0, 1);
        check("frz_retired", ret0, 3);
        check("frz_count", cnt0, 3);
        retire(32'h700, 32'h00000013);
        check("frz_retired_hold", ret0, 3);
        check("frz_count_hold", cnt0, 3);
        pop();
        check("frz_pop", cnt0, 2);
        check("frz_stays", fz0, 1);

        // reset mid-run
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mrst_count", cnt0, 0);
        check("mrst_retired", ret0, 0);
        check("mrst_frozen", fz0, 0);
        retire(32'h900, 32'h00000013);
        check("mrst_first_rdir", rr0, 0);
        check("mrst_retired1", ret0, 1);

        // link-value check on JAL at 0x0C, rd=x4
        do_clear();
        wb_regwrite = 1'b1; wb_rd = 5'd4; wb_wdata = 32'h10;
        retire(32'h0C, 32'h00C0026F);
        check("link_good", le0, 0);
        check("link_good_frozen", fz0, 0);
        do_clear();
        wb_regwrite = 1'b1; wb_rd = 5'd4; wb_wdata = 32'h14;
        retire(32'h0C, 32'h00C0026F);
        check("link_bad_count", cnt0, 1);
`ifdef TRACE_LINK_CHECK_EN
        check("link_bad_err", le0, 1);
        check("link_bad_pc", lp0, 32'h0C);
        check("link_bad_frozen", fz0, 1);
        retire(32'h10, 32'h00000013);
        check("link_bad_retired", ret0, 1);
`else
        check("link_absent_err", le0, 0);
        check("link_absent_pc", lp0, 0);
        check("link_absent_frozen", fz0, 0);
        retire(32'h10, 32'h00000013);
        check("link_absent_retired", ret0, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_trace_monitor.md
# wb_trace_monitor

Parametrised write-back retirement monitor for the PipelineCPU. It watches the WB stage, counts retired instructions and control-flow redirects, and buffers a trace of {PC, instr, redirect} entries in a DEPTH-deep FIFO that is read through a first-word-fall-through (FWFT) pop port. It replaces hand-written per-cycle `$display` probing of pipeline internals with a reusable block that is instantiated beside the CPU core and driven from its MEM/WB register outputs.

## Interface
- XLEN, 32, data/PC width
- DEPTH, 8, trace FIFO entries; power of two, ≥2
- CNTW, 32, width of retire/redirect counters
- OVERWRITE, 0, 0 = drop new entry when full; 1 = evict oldest

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- wb_valid  in  1  an instruction retires this cycle
- wb_pc  in  XLEN  PC of retiring instruction
- wb_instr  in  32  retiring instruction word
- wb_regwrite  in  1  retiring instruction writes rd
- wb_rd  in  5  destination register
- wb_wdata  in  XLEN  write-back data
- freeze  in  1  enter FROZEN
- clear  in  1  synchronous soft clear
- rd_en  in  1  pop FIFO head
- rd_valid  out  1  FIFO non-empty
- rd_pc  out  XLEN  head PC
- rd_instr  out  32  head instruction
- rd_redirect  out  1  head entry was a redirect
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: entry dropped or evicted
- retired  out  CNTW  retirement count
- redirects  out  CNTW  redirect count
- frozen  out  1  state == FROZEN
- link_err  out  1  sticky link-value error (macro only)
- link_err_pc  out  XLEN  PC of first link error (macro only)

## Operation
- States:
  - IDLE: no PC history yet.
  - TRACK: last_pc is valid.
  - FROZEN: capture and counting stop; FIFO reads still allowed.
- IDLE → TRACK on the first wb_valid. That retirement is pushed with redirect=0, and last_pc is loaded with wb_pc.
- In TRACK, on each wb_valid:
  - redirect = (wb_pc != last_pc + 4), computed modulo 2^XLEN.
  - retired increments; redirects increments if redirect=1.
  - The entry is pushed; last_pc is loaded with wb_pc.
- Counters wrap modulo 2^CNTW.
- freeze=1 in IDLE or TRACK → FROZEN next cycle. A retirement in the same cycle as freeze is still recorded.
- FROZEN exits only via clear or reset.
- clear=1 → IDLE. Clearing empties the FIFO and zeroes retired, redirects, overflow, link_err and link_err_pc. clear overrides wb_valid, freeze and rd_en in the same cycle.
- FIFO push when full:
  - OVERWRITE=0: entry dropped, overflow set; if rd_en is asserted the same cycle, the pop frees a slot and the push is accepted with no overflow.
  - OVERWRITE=1: oldest entry evicted, overflow set, count stays at DEPTH.
- Pop:
  - rd_en with rd_valid=1 advances the head.
  - rd_en on an empty FIFO is ignored.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
- rd_pc, rd_instr and rd_redirect are 0 when the FIFO is empty.

## Timing
- Reset (rst=0 at a clock edge) sets state IDLE, every output to 0 and the FIFO to empty. A reset mid-operation discards all entries.
- A retirement in cycle N is visible at rd_* (if it is the head), count, retired and redirects after edge N.
- Head outputs are combinational from FIFO storage (FWFT); pop takes effect at the edge.
- frozen rises one cycle after freeze is sampled.

## Configuration
- TRACE_LINK_CHECK_EN defined:
  - When a JAL (opcode 1101111) or JALR (opcode 1100111) retires with wb_regwrite=1 and wb_rd≠0, wb_wdata must equal wb_pc+4.
  - On mismatch: link_err is set, link_err_pc is captured (first error only), and the state moves to FROZEN on the next edge. The offending entry is still pushed.
- Not defined: the check logic is absent, and link_err and link_err_pc are tied to 0.

## Test plan
- Program ADDI/ADDI/ADD/JAL+12/…/ADD/ADDI retiring PCs 0x00,0x04,0x08,0x0C,0x18,0x1C → retired=6, redirects=1, count=6, popped redirect flags 0,0,0,0,1,0.
- TRACE_LINK_CHECK_EN, JAL at 0x0C with rd=x4, wdata=0x10 → link_err=0. Repeat with wdata=0x14 → link_err=1, link_err_pc=0x0C, frozen=1 next cycle, later retirements not counted.
- DEPTH=8, OVERWRITE=0, 10 sequential retirements from PC 0x00, no pops → count=8, overflow=1, rd_pc=0x00, retired=10.
- Same with OVERWRITE=1 → count=8, overflow=1, rd_pc=0x08. Then 8 pops → rd_valid=0, rd_pc=0.
- FIFO full with OVERWRITE=0, wb_valid and rd_en in the same cycle → count stays 8, overflow stays 0, new tail accepted.
- clear asserted together with wb_valid after 3 retirements → state IDLE, retired=0, count=0; the next retirement has redirect=0 whatever its PC. rst=0 mid-run gives the same result.
